// File: rtl/image_feeder_if.sv
// Host, status and classifier signals of the image feeder, grouped as one bus.
interface image_feeder_if #(
   parameter int PIX_W = 16
);
   logic             wr_en;
   logic [9:0]       wr_addr;
   logic [PIX_W-1:0] wr_data;
   logic             start;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [4:0]       result;
   logic [PIX_W-1:0] imagein;
   logic             valid;
   logic             cnn_reset;
   logic [4:0]       index_out;
   logic             index_valid;

   modport slave (
      input  wr_en, wr_addr, wr_data, start, index_out, index_valid,
      output busy, done, timeout, result, imagein, valid, cnn_reset
   );

   modport master (
      output wr_en, wr_addr, wr_data, start, index_out, index_valid,
      input  busy, done, timeout, result, imagein, valid, cnn_reset
   );
endinterface

// File: rtl/image_feeder.sv
// image_feeder: buffers one frame written by the host, then resets the
// classifier, streams the frame to it gap-free and latches its answer
// (or a timeout code if it never answers).
module image_feeder #(
   parameter int IMG_PIXELS = 1024,
   parameter int PIX_W      = 16,
   parameter int TIMEOUT    = 1048575
) (
   input logic           clk,
   input logic           reset_n,
   image_feeder_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CRST   = 3'd1;
   localparam logic [2:0] S_PREF   = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [9:0]  LAST_ADDR    = 10'(IMG_PIXELS - 1);
   localparam logic [19:0] WAIT_LIMIT   = 20'(TIMEOUT);
   localparam logic [4:0]  TIMEOUT_CODE = 5'd31;

   logic [PIX_W-1:0] mem [IMG_PIXELS];
   logic [2:0]       state;
   logic             crst_cnt;
   logic [9:0]       addr;
   logic [19:0]      wait_cnt;
   logic [19:0]      wait_nxt;
   logic             wr_ok;

   // Next value of the wait counter, compared against the limit before it is stored.
   always_comb wait_nxt = wait_cnt + 20'd1;

   // Host writes land only while idle/done and only inside the frame.
   always_comb wr_ok = bus.wr_en && !bus.busy && ({22'd0, bus.wr_addr} < IMG_PIXELS);

   // Frame buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
   end

   // Control FSM; the buffer read register doubles as the imagein output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         crst_cnt      <= 1'b0;
         addr          <= '0;
         wait_cnt      <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.timeout   <= 1'b0;
         bus.result    <= '0;
         bus.valid     <= 1'b0;
         bus.imagein   <= '0;
         bus.cnn_reset <= 1'b1;
      end else begin
         bus.cnn_reset <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state         <= S_CRST;
                  crst_cnt      <= 1'b0;
                  bus.busy      <= 1'b1;
                  bus.cnn_reset <= 1'b1;
                  bus.done      <= 1'b0;
                  bus.timeout   <= 1'b0;
                  bus.result    <= '0;
               end
            end
            S_CRST: begin
               // second CRST cycle lets cnn_reset fall, giving exactly two high cycles
               bus.cnn_reset <= ~crst_cnt;
               crst_cnt      <= 1'b1;
               addr          <= '0;
               if (crst_cnt) state <= S_PREF;
            end
            S_PREF: begin
               bus.imagein <= mem[10'd0];
               bus.valid   <= 1'b1;
               addr        <= '0;
               state       <= S_STREAM;
            end
            S_STREAM: begin
               // addr tracks the pixel on imagein and saturates at the last one
               if (addr == LAST_ADDR) begin
                  bus.valid <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= S_WAIT;
               end else begin
                  addr        <= addr + 10'd1;
                  bus.imagein <= mem[addr + 10'd1];
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_nxt;
               if (bus.index_valid) begin
                  bus.result <= bus.index_out;
                  bus.done   <= 1'b1;
                  bus.busy   <= 1'b0;
                  state      <= S_DONE;
               end else if (wait_nxt == WAIT_LIMIT) begin
                  bus.result  <= TIMEOUT_CODE;
                  bus.timeout <= 1'b1;
                  bus.done    <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= S_DONE;
               end
            end
            default: begin
               state     <= S_IDLE;
               bus.busy  <= 1'b0;
               bus.valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_image_feeder.sv
// Self-checking bench for image_feeder: scoreboard of expected pixels,
// a small classifier model answering a configurable delay after the frame.
module tb_image_feeder;
   localparam int IMG = 1024;
   localparam int PW  = 16;
   localparam int TMO = 100;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   tests = 0;
   int   errors = 0;

   image_feeder_if #(.PIX_W(PW)) bus ();

   image_feeder #(
      .IMG_PIXELS(IMG),
      .PIX_W     (PW),
      .TIMEOUT   (TMO)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [PW-1:0] pix_model [IMG];
   logic [PW-1:0] sb [$];

   // classifier model: answers resp_delay cycles after valid falls, holds until cnn_reset
   int       resp_delay = -1;
   logic [4:0] resp_idx = '0;
   bit       armed = 1'b0;
   int       cnt = 0;
   logic     prev_valid = 1'b0;

   always @(negedge clk) begin
      if (bus.cnn_reset === 1'b1) begin
         bus.index_valid = 1'b0;
         armed = 1'b0;
      end else if (armed) begin
         if (cnt <= 1) begin
            bus.index_valid = 1'b1;
            bus.index_out   = resp_idx;
            armed = 1'b0;
         end else begin
            cnt--;
         end
      end else if (prev_valid === 1'b1 && bus.valid === 1'b0 && resp_delay > 0) begin
         armed = 1'b1;
         cnt   = resp_delay;
      end
      prev_valid = bus.valid;
   end

   task automatic test_reset();
      #3 reset_n = 1'b0;
      #1;
      tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      tests++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      tests++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
      tests++; if (bus.result !== 5'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
      tests++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
      tests++; if (bus.imagein !== 16'h0) begin errors++; $display("FAIL reset_imagein: got %h expected 0", bus.imagein); end
      tests++; if (bus.cnn_reset !== 1'b1) begin errors++; $display("FAIL reset_cnn_reset: got %b expected 1", bus.cnn_reset); end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (bus.cnn_reset !== 1'b0) begin errors++; $display("FAIL reset_release_cnn_reset: got %b expected 0", bus.cnn_reset); end
      tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic write_pix(input int a, input logic [PW-1:0] d);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = 10'(a); bus.wr_data = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
      pix_model[a] = d;
   endtask

   task automatic load_frame();
      for (int k = 0; k < IMG; k++) begin
         @(negedge clk);
         bus.wr_en = 1'b1; bus.wr_addr = 10'(k); bus.wr_data = PW'(k);
         pix_model[k] = PW'(k);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   // One full frame: start pulse, stream scoreboard, answer or timeout, hold in DONE.
   // delay < 0 means the classifier never answers. poke injects busy-time writes/start/index.
   task automatic test_frame(input string name, input int delay, input logic [4:0] idx, input bit poke);
      int exp_done_n, bad_busy, bad_cr, bad_hold, nvalid;
      logic [PW-1:0] exp;
      logic [4:0] exp_res;
      logic exp_to;
      bad_busy = 0; bad_cr = 0; bad_hold = 0; nvalid = 0;
      exp_done_n = (delay > 0) ? 1029 + delay : 1028 + TMO;
      exp_res    = (delay > 0) ? idx : 5'd31;
      exp_to     = (delay > 0) ? 1'b0 : 1'b1;
      resp_delay = delay;
      resp_idx   = idx;
      sb.delete();
      for (int k = 0; k < IMG; k++) sb.push_back(pix_model[k]);
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      for (int n = 1; n <= exp_done_n + 20; n++) begin
         if (n > 1) @(negedge clk);
         if (poke && n == 100) begin
            bus.wr_en = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 16'hFFFF; bus.start = 1'b1;
         end
         if (poke && n == 101) begin
            bus.wr_en = 1'b0; bus.start = 1'b0;
         end
         if (poke && n == 300) begin bus.index_valid = 1'b1; bus.index_out = 5'd9; end
         if (poke && n == 301) bus.index_valid = 1'b0;
         if (n <= 4) begin
            tests++;
            if (bus.cnn_reset !== (n <= 2)) begin
               errors++; $display("FAIL %s cnn_reset_c%0d: got %b expected %b", name, n, bus.cnn_reset, (n <= 2));
            end
         end else if (bus.cnn_reset !== 1'b0) bad_cr++;
         if (n == 1) begin
            tests++; if (bus.result !== 5'd0) begin errors++; $display("FAIL %s result_cleared: got %0d expected 0", name, bus.result); end
            tests++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_cleared: got %b expected 0", name, bus.done); end
            tests++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL %s timeout_cleared: got %b expected 0", name, bus.timeout); end
         end
         if (bus.valid === 1'b1) begin
            if (sb.size() == 0) begin
               tests++; errors++; $display("FAIL %s extra_pixel: got valid at cycle %0d expected none", name, n);
            end else begin
               exp = sb.pop_front();
               tests++;
               if (bus.imagein !== exp) begin
                  errors++; $display("FAIL %s pixel%0d: got %h expected %h", name, nvalid, bus.imagein, exp);
               end
               tests++;
               if (n != 4 + nvalid) begin
                  errors++; $display("FAIL %s pixel%0d_cycle: got %0d expected %0d", name, nvalid, n, 4 + nvalid);
               end
               nvalid++;
            end
         end
         if (n == 1028) begin
            tests++;
            if (bus.imagein !== pix_model[IMG-1]) begin
               errors++; $display("FAIL %s imagein_held: got %h expected %h", name, bus.imagein, pix_model[IMG-1]);
            end
         end
         if (n < exp_done_n) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
         end else if (n == exp_done_n) begin
            tests++; if (bus.done !== 1'b1) begin errors++; $display("FAIL %s done: got %b expected 1", name, bus.done); end
            tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b expected 0", name, bus.busy); end
            tests++; if (bus.timeout !== exp_to) begin errors++; $display("FAIL %s timeout: got %b expected %b", name, bus.timeout, exp_to); end
            tests++; if (bus.result !== exp_res) begin errors++; $display("FAIL %s result: got %0d expected %0d", name, bus.result, exp_res); end
         end else if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== exp_res || bus.timeout !== exp_to) begin
            bad_hold++;
         end
      end
      tests++; if (nvalid != IMG) begin errors++; $display("FAIL %s pixel_count: got %0d expected %0d", name, nvalid, IMG); end
      tests++; if (sb.size() != 0) begin errors++; $display("FAIL %s sb_left: got %0d expected 0", name, sb.size()); end
      tests++; if (bad_cr != 0) begin errors++; $display("FAIL %s cnn_reset_late: got %0d cycles expected 0", name, bad_cr); end
      tests++; if (bad_busy != 0) begin errors++; $display("FAIL %s busy_run: got %0d bad cycles expected 0", name, bad_busy); end
      tests++; if (bad_hold != 0) begin errors++; $display("FAIL %s done_hold: got %0d bad cycles expected 0", name, bad_hold); end
   endtask

   task automatic test_classify();
      test_frame("classify", 30, 5'd7, 1'b0);
   endtask

   task automatic test_stale_index();
      tests++;
      if (bus.index_valid !== 1'b1) begin
         errors++; $display("FAIL stale_setup: got index_valid %b expected 1", bus.index_valid);
      end
      test_frame("stale", 10, 5'd3, 1'b0);
   endtask

   task automatic test_timeout();
      test_frame("timeout", -1, 5'd0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      test_frame("busy_ignore", 30, 5'd2, 1'b1);
   endtask

   task automatic test_idle_write_rerun();
      write_pix(0, 16'h1234);
      write_pix(IMG - 1, 16'hABCD);
      test_frame("rerun", 5, 5'd9, 1'b0);
   endtask

   task automatic test_reset_abort();
      int bad;
      bad = 0;
      resp_delay = 30;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      for (int n = 2; n <= 503; n++) @(negedge clk);
      tests++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b expected 1", bus.valid); end
      reset_n = 1'b0;
      #1;
      tests++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.valid); end
      tests++; if (bus.cnn_reset !== 1'b1) begin errors++; $display("FAIL abort_cnn_reset: got %b expected 1", bus.cnn_reset); end
      tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
      tests++; if (bus.imagein !== 16'h0) begin errors++; $display("FAIL abort_imagein: got %h expected 0", bus.imagein); end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.cnn_reset !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad); end
      test_frame("after_abort", 30, 5'd4, 1'b0);
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
      bus.index_valid = 1'b0; bus.index_out = '0;
      test_reset();
      load_frame();
      test_classify();
      test_stale_index();
      test_timeout();
      test_busy_ignore();
      test_idle_write_rerun();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
